// File: rtl/id_fwd_stage.sv
// Decode stage with N-source operand forwarding, load-use stall and a registered ID/EX output.
// Define ID_STALL_CNT_EN to add a saturating hazard-cycle counter (stall_cnt_o / stall_cnt_clr_i).
module id_fwd_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_N  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_W-1:0]       pc_i,
    input  logic [31:0]             inst_i,
    output logic [REG_AW-1:0]       reg1_addr_o,
    output logic [REG_AW-1:0]       reg2_addr_o,
    output logic                    reg1_read_o,
    output logic                    reg2_read_o,
    input  logic [DATA_W-1:0]       reg1_data_i,
    input  logic [DATA_W-1:0]       reg2_data_i,
    input  logic [FWD_N-1:0]        fwd_wreg_i,
    input  logic [FWD_N*REG_AW-1:0] fwd_waddr_i,
    input  logic [FWD_N*DATA_W-1:0] fwd_wdata_i,
    input  logic [FWD_N-1:0]        fwd_pending_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [2:0]              alusel_o,
    output logic [7:0]              aluop_o,
    output logic [DATA_W-1:0]       reg1_data_o,
    output logic [DATA_W-1:0]       reg2_data_o,
    output logic [REG_AW-1:0]       waddr_o,
    output logic                    wreg_o,
    output logic [DATA_W-1:0]       pc_o,
    output logic                    inst_invalid_o
`ifdef ID_STALL_CNT_EN
    ,
    input  logic                    stall_cnt_clr_i,
    output logic [31:0]             stall_cnt_o
`endif
);
    localparam logic [2:0] ALU_RES_NOP   = 3'b000;
    localparam logic [2:0] ALU_RES_LOGIC = 3'b001;
    localparam logic [2:0] ALU_RES_SHIFT = 3'b010;
    localparam logic [7:0] ALU_NOP_OP    = 8'h00;
    localparam logic [7:0] ALU_AND_OP    = 8'h24;
    localparam logic [7:0] ALU_OR_OP     = 8'h25;
    localparam logic [7:0] ALU_XOR_OP    = 8'h26;
    localparam logic [7:0] ALU_NOR_OP    = 8'h27;
    localparam logic [7:0] ALU_SLL_OP    = 8'h7C;
    localparam logic [7:0] ALU_SRL_OP    = 8'h02;
    localparam logic [7:0] ALU_SRA_OP    = 8'h03;

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    assign {op, rs, rt, rd, sa, fn} = inst_i;

    logic [2:0]               alusel_d;
    logic [7:0]               aluop_d;
    logic                     wreg_d, invalid_d;
    logic [REG_AW-1:0]        waddr_d;
    logic [1:0]               rd_en;
    logic [1:0][REG_AW-1:0]   rd_addr;
    logic [DATA_W-1:0]        imm;

    always_comb begin
        alusel_d   = ALU_RES_NOP;
        aluop_d    = ALU_NOP_OP;
        wreg_d     = 1'b0;
        waddr_d    = '0;
        invalid_d  = 1'b0;
        rd_en      = 2'b00;
        rd_addr[0] = REG_AW'(rs);
        rd_addr[1] = REG_AW'(rt);
        imm        = '0;
        case (op)
            6'h00: begin
                if (rs == 5'd0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
                    // immediate shifts: rt through port 1, shamt through port 2
                    alusel_d   = ALU_RES_SHIFT;
                    aluop_d    = (fn == 6'h00) ? ALU_SLL_OP : (fn == 6'h02) ? ALU_SRL_OP : ALU_SRA_OP;
                    wreg_d     = 1'b1;
                    waddr_d    = REG_AW'(rd);
                    rd_en      = 2'b01;
                    rd_addr[0] = REG_AW'(rt);
                    imm        = DATA_W'(sa);
                end else if (sa == 5'd0) begin
                    case (fn)
                        6'h24, 6'h25, 6'h26, 6'h27: begin
                            alusel_d = ALU_RES_LOGIC;
                            aluop_d  = (fn == 6'h24) ? ALU_AND_OP : (fn == 6'h25) ? ALU_OR_OP :
                                       (fn == 6'h26) ? ALU_XOR_OP : ALU_NOR_OP;
                            wreg_d   = 1'b1;
                            waddr_d  = REG_AW'(rd);
                            rd_en    = 2'b11;
                        end
                        6'h04, 6'h06, 6'h07: begin
                            alusel_d   = ALU_RES_SHIFT;
                            aluop_d    = (fn == 6'h04) ? ALU_SLL_OP : (fn == 6'h06) ? ALU_SRL_OP : ALU_SRA_OP;
                            wreg_d     = 1'b1;
                            waddr_d    = REG_AW'(rd);
                            rd_en      = 2'b11;
                            rd_addr[0] = REG_AW'(rt);
                            rd_addr[1] = REG_AW'(rs);
                        end
                        6'h0F: ;  // SYNC
                        default: invalid_d = 1'b1;
                    endcase
                end else begin
                    invalid_d = 1'b1;
                end
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                alusel_d = ALU_RES_LOGIC;
                aluop_d  = (op == 6'h0C) ? ALU_AND_OP : (op == 6'h0E) ? ALU_XOR_OP : ALU_OR_OP;
                wreg_d   = 1'b1;
                waddr_d  = REG_AW'(rt);
                rd_en    = 2'b01;
                imm      = (op == 6'h0F) ? DATA_W'({inst_i[15:0], 16'h0000}) : DATA_W'(inst_i[15:0]);
            end
            6'h33: ;  // PREF
            default: invalid_d = 1'b1;
        endcase
    end

    // Lowest-index matching source wins; scanning downward lets it overwrite older ones.
    logic [1:0][DATA_W-1:0] rf_data, opnd;
    logic [1:0]             pend;
    assign rf_data = {reg2_data_i, reg1_data_i};

    always_comb begin
        opnd = '0;
        pend = '0;
        for (int p = 0; p < 2; p++) begin
            opnd[p] = (p == 1) ? imm : '0;
            if (rd_en[p]) begin
                opnd[p] = rf_data[p];
                for (int i = FWD_N - 1; i >= 0; i--) begin
                    if (fwd_wreg_i[i] && fwd_waddr_i[i*REG_AW +: REG_AW] == rd_addr[p]) begin
                        opnd[p] = fwd_wdata_i[i*DATA_W +: DATA_W];
                        pend[p] = fwd_pending_i[i];
                    end
                end
                if (rd_addr[p] == '0) begin
                    opnd[p] = '0;
                    pend[p] = 1'b0;
                end
            end
        end
    end

    logic hazard;
    assign hazard      = in_valid_i && (|pend);
    assign in_ready_o  = !hazard && (!out_valid_o || out_ready_i);
    assign reg1_addr_o = rd_addr[0];
    assign reg2_addr_o = rd_addr[1];
    assign reg1_read_o = rd_en[0];
    assign reg2_read_o = rd_en[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o    <= 1'b0;
            alusel_o       <= ALU_RES_NOP;
            aluop_o        <= ALU_NOP_OP;
            reg1_data_o    <= '0;
            reg2_data_o    <= '0;
            waddr_o        <= '0;
            wreg_o         <= 1'b0;
            pc_o           <= '0;
            inst_invalid_o <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            out_valid_o    <= 1'b1;
            alusel_o       <= alusel_d;
            aluop_o        <= aluop_d;
            reg1_data_o    <= opnd[0];
            reg2_data_o    <= opnd[1];
            waddr_o        <= waddr_d;
            wreg_o         <= wreg_d;
            pc_o           <= pc_i;
            inst_invalid_o <= invalid_d;
        end else if (out_ready_i && out_valid_o) begin
            out_valid_o <= 1'b0;
            if (hazard) begin  // bubble: make the drained slot inert
                alusel_o <= ALU_RES_NOP;
                aluop_o  <= ALU_NOP_OP;
                wreg_o   <= 1'b0;
            end
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_o <= '0;
        else if (stall_cnt_clr_i)
            stall_cnt_o <= '0;
        else if (hazard && stall_cnt_o != 32'hFFFF_FFFF)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: doc/id_fwd_stage.md
Name: id_fwd_stage

Overview:
- Parameterised successor to the combinational decode stage: decodes the logic/shift/immediate subset and selects operands over N forwarding sources.
- Adds a registered ID/EX output with a valid/ready handshake, flush, and load-use hazard detection with bubble insertion.
- Sits between the IF/ID register and the EX stage; it replaces the separate id_ex register.

Parameters:
DATA_W, 32, datapath and register width
REG_AW, 5, register address width
FWD_N, 2, number of forwarding sources; index 0 = youngest (EX), higher = older (MEM, WB, ...)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid_i  in  1  IF/ID holds a valid instruction
in_ready_o  out  1  stage accepts the instruction this cycle
pc_i  in  DATA_W  instruction address
inst_i  in  32  instruction word
reg1_addr_o / reg2_addr_o  out  REG_AW each  regfile read addresses (combinational)
reg1_read_o / reg2_read_o  out  1 each  regfile read enables (combinational)
reg1_data_i / reg2_data_i  in  DATA_W each  regfile read data
fwd_wreg_i  in  FWD_N  per-source write enable
fwd_waddr_i  in  FWD_N*REG_AW  per-source destination, source i at [i*REG_AW +: REG_AW]
fwd_wdata_i  in  FWD_N*DATA_W  per-source result
fwd_pending_i  in  FWD_N  per-source result not yet available (load in flight)
flush_i  in  1  kill the registered and incoming instruction
out_valid_o  out  1  ID/EX register valid
out_ready_i  in  1  EX accepts
alusel_o  out  3  registered, ALU_RES_* codes from defines.v
aluop_o  out  8  registered, ALU_*_OP codes from defines.v
reg1_data_o / reg2_data_o  out  DATA_W each  registered operands
waddr_o  out  REG_AW  registered destination
wreg_o  out  1  registered write enable
pc_o  out  DATA_W  registered pc
inst_invalid_o  out  1  registered: decoded instruction not in supported set

Behaviour:
- Reset (rst=0, async): out_valid_o=0, alusel_o=ALU_RES_NOP, aluop_o=ALU_NOP_OP, data/addr/pc outputs=0, wreg_o=0, inst_invalid_o=0.
- Decode set: AND, OR, XOR, NOR, SLLV, SRLV, SRAV, SYNC, SLL, SRL, SRA, ORI, ANDI, XORI, LUI, PREF.
  - Shift-variable ops: op1=rt, op2=rs.
  - Immediate shifts: op1=rt, op2={0,shamt}.
  - ORI/ANDI/XORI: op2 = zero-extended imm16.
  - LUI: OR of rs with {imm16,16'b0}.
  - SYNC/PREF: NOP with wreg=0.
  - Any other encoding: NOP control, wreg=0, inst_invalid=1.
- Operand select, per read port, when the read is enabled:
  - Address 0 always yields 0; $0 is never forwarded.
  - Otherwise the lowest-index source i with fwd_wreg_i[i] and a matching waddr supplies fwd_wdata_i[i].
  - If no source matches, the regfile data is used.
  - Matching is on address, never on data.
  - When the read is disabled, the port yields the immediate (port 2) or 0 (port 1).
- Hazard: hazard = in_valid_i and some enabled read port's winning match has fwd_pending_i=1. A pending older source shadowed by a younger non-pending match is not a hazard.
- in_ready_o = !hazard && (!out_valid_o || out_ready_i).
- Register update each clk, priority order:
  1. flush_i: out_valid_o<=0.
  2. in_valid_i && in_ready_o: load the decoded fields, out_valid_o<=1.
  3. out_ready_i && out_valid_o: out_valid_o<=0. On a hazard this is the bubble; control fields are forced to NOP.
  4. Otherwise hold all fields.
- Latency: 1 cycle from acceptance to out_valid_o.
- A hazard persists while the pending source remains; the instruction stays in IF/ID, which IF must hold while in_ready_o=0.
- flush_i during a hazard drops the hazard effect; in_ready_o is unaffected by flush.
- Reset mid-stall: all state cleared, no residual bubble.

Optional Feature:
- ID_STALL_CNT_EN defined: adds output stall_cnt_o (32) and input stall_cnt_clr_i.
  - Counter increments every cycle hazard=1 and saturates at 0xFFFFFFFF.
  - Synchronous clear; clear wins over increment.
  - Async reset to 0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Independent instruction: ori $1,$0,0x1234 (0x34011234), no forwards -> next cycle out_valid=1, aluop=ALU_OR_OP, reg1_data=0, reg2_data=0x00001234, waddr=1, wreg=1.
- Forward priority: or $3,$1,$2 (0x00221825), source 0 writes $1=0xAAAA0000, source 1 writes $1=0x5555 and $2=0x0F0F -> reg1_data=0xAAAA0000, reg2_data=0x0F0F.
- Load-use stall: sll $4,$2,3 (0x000220C0) with source 0 waddr=2 and pending=1 for 2 cycles -> in_ready_o=0 for 2 cycles and two bubbles (out_valid=0) are emitted; on cycle 3 the instruction issues with reg2_data=3; stall_cnt_o=2 if ID_STALL_CNT_EN is defined.
- Backpressure: out_ready_i=0 for 3 cycles with lui $5,0xABCD (0x3C05ABCD) registered -> outputs stable with reg2_data=0xABCD0000; in_ready_o=0 throughout.
- $0 and invalid: and $6,$0,$0 with a forwarding source writing $0=0xFFFFFFFF -> reg1_data=reg2_data=0; opcode 0xFC000000 -> inst_invalid_o=1, wreg_o=0.
- Flush and reset: flush_i together with a valid input -> out_valid=0 next cycle; rst low mid-stall -> all outputs at reset values immediately.
